// File: rtl/spi_cfg_regbank.sv
// rtl/spi_cfg_regbank.sv - SPI slave, shadow/active register bank and commit sequencer
// Optional macro SPI_PARITY_EN appends an even-parity bit to frames and readback.
module spi_cfg_regbank #(
  parameter int                ADDR_W  = 6,
  parameter int                DATA_W  = 16,
  parameter int                NREG    = 32,
  parameter logic [DATA_W-1:0] RST_VAL = '0,
  parameter int                RST_CYC = 20,
  parameter int                CFG_CYC = 20
) (
  input  logic                   CLK,
  input  logic                   NARST,
  input  logic                   SCK,
  input  logic                   CSN,
  input  logic                   MOSI,
  output logic                   MISO,
  output logic [NREG*DATA_W-1:0] CFG_BUS,
  output logic                   CFG_CONFIG,
  output logic                   CFG_NARST_OUT,
  output logic                   BUSY,
  output logic [7:0]             ERR_CNT
);
`ifdef SPI_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FL   = 1 + ADDR_W + DATA_W + PB;
  localparam int CW   = $clog2(FL + 2);
  localparam int TXW  = DATA_W + PB;
  localparam int TXCW = $clog2(TXW + 1);
  localparam int TW   = $clog2(((RST_CYC > CFG_CYC) ? RST_CYC : CFG_CYC) + 1);
  localparam logic [ADDR_W-1:0] CMD_ADDR = '1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RSTP  = 2'd1;
  localparam logic [1:0] S_COPY  = 2'd2;
  localparam logic [1:0] S_PULSE = 2'd3;

  logic [2:0] sck_q, csn_q;
  logic [1:0] mosi_q;
  logic       sck_rise, sck_fall, csn_rise, csn_fall, csn_low;

  // CSN synchroniser resets high so reset release never looks like a frame end
  always_ff @(posedge CLK or negedge NARST) begin
    if (!NARST) begin
      sck_q  <= '0;
      csn_q  <= '1;
      mosi_q <= '0;
    end else begin
      sck_q  <= {sck_q[1:0], SCK};
      csn_q  <= {csn_q[1:0], CSN};
      mosi_q <= {mosi_q[0], MOSI};
    end
  end

  assign sck_rise = sck_q[1] & ~sck_q[2];
  assign sck_fall = ~sck_q[1] & sck_q[2];
  assign csn_rise = csn_q[1] & ~csn_q[2];
  assign csn_fall = ~csn_q[1] & csn_q[2];
  assign csn_low  = ~csn_q[1];

  logic [FL-1:0] sh, sh_nxt;
  logic [CW-1:0] cnt;

  assign sh_nxt = {sh[FL-2:0], mosi_q[1]};

  always_ff @(posedge CLK or negedge NARST) begin
    if (!NARST) begin
      sh  <= '0;
      cnt <= '0;
    end else if (csn_fall) begin
      cnt <= '0;
    end else if (sck_rise && csn_low) begin
      sh <= sh_nxt;
      if (cnt != CW'(FL + 1)) cnt <= cnt + CW'(1);
    end
  end

  logic              f_w, f_ok, wr_en, cmd_req, err_inc;
  logic [ADDR_W-1:0] f_addr;
  logic [DATA_W-1:0] f_data;
  logic [1:0]        state, state_nxt;

  assign f_w    = sh[FL-1];
  assign f_addr = sh[FL-2 -: ADDR_W];
  assign f_data = sh[PB +: DATA_W];
`ifdef SPI_PARITY_EN
  assign f_ok = (cnt == CW'(FL)) && !(^sh);
`else
  assign f_ok = (cnt == CW'(FL));
`endif
  assign wr_en   = csn_rise & f_ok & f_w & (int'(f_addr) < NREG);
  assign cmd_req = csn_rise & f_ok & f_w & (f_addr == CMD_ADDR);
  assign err_inc = (csn_rise & ~f_ok) | (cmd_req & (state != S_IDLE));

  logic [DATA_W-1:0] shadow     [NREG];
  logic [DATA_W-1:0] shadow_nxt [NREG];
  logic [DATA_W-1:0] active     [NREG];

  // COPY samples the next-shadow value so a write landing in that cycle is included
  always_comb begin
    for (int k = 0; k < NREG; k++)
      shadow_nxt[k] = (wr_en && f_addr == ADDR_W'(k)) ? f_data : shadow[k];
  end

  always_ff @(posedge CLK or negedge NARST) begin
    if (!NARST) begin
      for (int k = 0; k < NREG; k++) begin
        shadow[k] <= RST_VAL;
        active[k] <= RST_VAL;
      end
    end else begin
      for (int k = 0; k < NREG; k++) begin
        shadow[k] <= shadow_nxt[k];
        if (state == S_COPY) active[k] <= shadow_nxt[k];
      end
    end
  end

  for (genvar k = 0; k < NREG; k++) begin : g_bus
    assign CFG_BUS[k*DATA_W +: DATA_W] = active[k];
  end

  logic              rd_load;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [TXW-1:0]    tx_val, tx_sh;
  logic [TXCW-1:0]   tx_left;

  // the rise that shifts in the last address bit of a read frame loads the shifter
  assign rd_load = sck_rise & csn_low & (cnt == CW'(ADDR_W)) & ~sh_nxt[ADDR_W];
  assign rd_addr = sh_nxt[ADDR_W-1:0];

  always_comb begin
    rd_data = '0;
    for (int k = 0; k < NREG; k++)
      if (rd_addr == ADDR_W'(k)) rd_data = shadow[k];
  end

`ifdef SPI_PARITY_EN
  assign tx_val = {rd_data, ^rd_data};
`else
  assign tx_val = rd_data;
`endif

  always_ff @(posedge CLK or negedge NARST) begin
    if (!NARST) begin
      MISO    <= 1'b0;
      tx_sh   <= '0;
      tx_left <= '0;
    end else if (!csn_low) begin
      MISO    <= 1'b0;
      tx_left <= '0;
    end else if (rd_load) begin
      tx_sh   <= tx_val;
      tx_left <= TXCW'(TXW);
    end else if (sck_fall) begin
      if (tx_left != '0) begin
        MISO    <= tx_sh[TXW-1];
        tx_sh   <= tx_sh << 1;
        tx_left <= tx_left - TXCW'(1);
      end else begin
        MISO <= 1'b0;
      end
    end
  end

  logic [TW-1:0] tmr;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (cmd_req && f_data[0]) state_nxt = f_data[1] ? S_RSTP : S_COPY;
      S_RSTP:  if (tmr == '0) state_nxt = S_COPY;
      S_COPY:  state_nxt = S_PULSE;
      default: if (tmr == '0) state_nxt = S_IDLE;
    endcase
  end

  // outputs are registered from the next state so they align exactly with the state
  always_ff @(posedge CLK or negedge NARST) begin
    if (!NARST) begin
      state         <= S_IDLE;
      tmr           <= '0;
      BUSY          <= 1'b0;
      CFG_CONFIG    <= 1'b0;
      CFG_NARST_OUT <= 1'b1;
      ERR_CNT       <= '0;
    end else begin
      state         <= state_nxt;
      BUSY          <= (state_nxt != S_IDLE);
      CFG_CONFIG    <= (state_nxt == S_PULSE);
      CFG_NARST_OUT <= (state_nxt != S_RSTP);
      if (state_nxt != state)
        tmr <= (state_nxt == S_RSTP) ? TW'(RST_CYC - 1) : TW'(CFG_CYC - 1);
      else if (tmr != '0)
        tmr <= tmr - TW'(1);
      if (err_inc && ERR_CNT != 8'hFF) ERR_CNT <= ERR_CNT + 8'd1;
    end
  end

endmodule

// File: tb/tb_spi_cfg_regbank.sv
// tb/tb_spi_cfg_regbank.sv - randomized self-checking bench for spi_cfg_regbank
module tb_spi_cfg_regbank;
  localparam int ADDR_W  = 6;
  localparam int DATA_W  = 16;
  localparam int NREG    = 32;
  localparam int RST_CYC = 120;
  localparam int CFG_CYC = 20;
`ifdef SPI_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FL  = 1 + ADDR_W + DATA_W + PB;
  localparam int BW  = NREG * DATA_W;
  localparam int CMD = 2**ADDR_W - 1;

  logic          CLK = 1'b0, NARST = 1'b0, SCK = 1'b0, CSN = 1'b1, MOSI = 1'b0;
  logic          MISO, CFG_CONFIG, CFG_NARST_OUT, BUSY;
  logic [BW-1:0] CFG_BUS;
  logic [7:0]    ERR_CNT;

  spi_cfg_regbank #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NREG(NREG),
    .RST_VAL('0), .RST_CYC(RST_CYC), .CFG_CYC(CFG_CYC)
  ) dut (
    .CLK(CLK), .NARST(NARST), .SCK(SCK), .CSN(CSN), .MOSI(MOSI),
    .MISO(MISO), .CFG_BUS(CFG_BUS), .CFG_CONFIG(CFG_CONFIG),
    .CFG_NARST_OUT(CFG_NARST_OUT), .BUSY(BUSY), .ERR_CNT(ERR_CNT)
  );

  always #5 CLK = ~CLK;

  int checks = 0, failures = 0;
  int cyc = 0, csn_hi = 0;

  // reference: register arrays plus the timeline windows a commit must produce
  typedef struct {int at; int kind; int addr; logic [DATA_W-1:0] data;} ev_t;
  ev_t               evq[$];
  logic [DATA_W-1:0] shadow_m [NREG];
  logic [DATA_W-1:0] active_m [NREG];
  int err_m, busy_from, busy_to, rst_to, copy_at, cfg_from, cfg_to;

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit in_win(input int c, input int a, input int b);
    return (c >= a) && (c <= b);
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < NREG; k++) begin
      shadow_m[k] = '0;
      active_m[k] = '0;
    end
    err_m = 0; busy_from = -100; busy_to = -200; rst_to = -200;
    copy_at = -100; cfg_from = -100; cfg_to = -200;
    evq.delete();
  endfunction

  function automatic void model_step();
    ev_t ev;
    int  r;
    while (evq.size() > 0 && evq[0].at <= cyc) begin
      ev = evq.pop_front();
      if (ev.kind == 0) begin
        if (err_m < 255) err_m++;
      end else if (ev.kind == 1) begin
        shadow_m[ev.addr] = ev.data;
      end else if (in_win(cyc - 1, busy_from, busy_to)) begin
        if (err_m < 255) err_m++;
      end else if (ev.data[0]) begin
        r = ev.data[1] ? RST_CYC : 0;
        busy_from = cyc;         rst_to = cyc + r - 1;
        copy_at   = cyc + r + 1; cfg_from = cyc + r + 1;
        cfg_to    = cyc + r + CFG_CYC; busy_to = cfg_to;
      end
    end
    if (cyc == copy_at)
      for (int k = 0; k < NREG; k++) active_m[k] = shadow_m[k];
  endfunction

  initial begin : compare
    logic [BW-1:0] flat;
    forever begin
      @(negedge CLK);
      cyc++;
      model_step();
      for (int k = 0; k < NREG; k++) flat[k*DATA_W +: DATA_W] = active_m[k];
      chk("busy",      BW'(BUSY),          BW'(in_win(cyc, busy_from, busy_to)));
      chk("config",    BW'(CFG_CONFIG),    BW'(in_win(cyc, cfg_from, cfg_to)));
      chk("narst_out", BW'(CFG_NARST_OUT), BW'(!in_win(cyc, busy_from, rst_to)));
      chk("err_cnt",   BW'(ERR_CNT),       BW'(err_m));
      chk("cfg_bus",   CFG_BUS,            flat);
      if (CSN) csn_hi++; else csn_hi = 0;
      if (csn_hi > 4) chk("miso_idle", BW'(MISO), BW'(0));
    end
  end

  task automatic spi_xfer(input int nbits, input logic w, input int a, input logic [DATA_W-1:0] d,
                          input int half, output logic [DATA_W-1:0] rd);
    logic [FL-1:0]     full;
    logic [63:0]       smp;
    logic [ADDR_W-1:0] aa;
    logic [DATA_W-1:0] exp;
    aa  = ADDR_W'(a);
    smp = '0;
`ifdef SPI_PARITY_EN
    full = {w, aa, d, ^{w, aa, d}};
`else
    full = {w, aa, d};
`endif
    @(negedge CLK); #1; CSN = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      if (i < FL) MOSI = full[FL-1-i];
      else MOSI = 1'b0;
      repeat (half) @(negedge CLK);
      #1; smp = {smp[62:0], MISO}; SCK = 1'b1;
      repeat (half) @(negedge CLK);
      #1; SCK = 1'b0;
    end
    repeat (half) @(negedge CLK);
    #1; CSN = 1'b1; MOSI = 1'b0;
    rd = smp[PB +: DATA_W];
    if (nbits != FL) evq.push_back('{cyc + 3, 0, 0, '0});
    else if (w && a < NREG) evq.push_back('{cyc + 3, 1, a, d});
    else if (w && a == CMD) evq.push_back('{cyc + 3, 2, 0, d});
    if (!w && nbits == FL) begin
      exp = (a < NREG) ? shadow_m[a] : '0;
      chk("readback", BW'(rd), BW'(exp));
    end
  endtask

  task automatic measure(input int n, output int first_cfg, output int cfg_n,
                         output int busy_n, output int nlow_n);
    int c0;
    c0 = cyc; first_cfg = -1; cfg_n = 0; busy_n = 0; nlow_n = 0;
    repeat (n) begin
      @(negedge CLK); #1;
      if (CFG_CONFIG) begin
        cfg_n++;
        if (first_cfg < 0) first_cfg = cyc - c0;
      end
      if (BUSY) busy_n++;
      if (!CFG_NARST_OUT) nlow_n++;
    end
  endtask

  task automatic do_reset();
    @(negedge CLK); #1; NARST = 1'b0; model_reset();
    repeat (3) @(negedge CLK);
    #1; NARST = 1'b1;
  endtask

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [DATA_W-1:0] rdv, d;
    int fc, cn, bn, nl, ok;
    model_reset();
    repeat (3) @(negedge CLK);
    #1; NARST = 1'b1;
    chk("rst_bus",   CFG_BUS,             BW'(0));
    chk("rst_narst", BW'(CFG_NARST_OUT),  BW'(1));
    chk("rst_busy",  BW'(BUSY),           BW'(0));
    chk("rst_err",   BW'(ERR_CNT),        BW'(0));
    chk("rst_miso",  BW'(MISO),           BW'(0));

    spi_xfer(FL, 1'b0, 5, 16'h0, 4, rdv);
    chk("read5_lit", BW'(rdv), BW'(16'h0000));
    spi_xfer(FL, 1'b1, 3, 16'hA5C3, 4, rdv);
    spi_xfer(FL, 1'b0, 3, 16'h0, 4, rdv);
    chk("read3_lit", BW'(rdv), BW'(16'hA5C3));
    chk("bus3_pre",  BW'(CFG_BUS[63:48]), BW'(16'h0000));

    spi_xfer(FL, 1'b1, CMD, 16'h0001, 4, rdv);
    measure(60, fc, cn, bn, nl);
    chk("c1_first_cfg", BW'(fc), BW'(4));
    chk("c1_cfg_len",   BW'(cn), BW'(20));
    chk("c1_busy_len",  BW'(bn), BW'(21));
    chk("c1_narst_low", BW'(nl), BW'(0));
    chk("c1_bus3",      BW'(CFG_BUS[63:48]), BW'(16'hA5C3));

    spi_xfer(FL, 1'b1, CMD, 16'h0003, 4, rdv);
    measure(200, fc, cn, bn, nl);
    chk("c3_first_cfg", BW'(fc), BW'(124));
    chk("c3_cfg_len",   BW'(cn), BW'(20));
    chk("c3_busy_len",  BW'(bn), BW'(141));
    chk("c3_narst_low", BW'(nl), BW'(120));

    for (int it = 0; it < 50; it++) begin
      int r, a, nb;
      r = $urandom_range(0, 9);
      d = DATA_W'($urandom);
      if (r <= 5) begin
        a = (r == 5) ? $urandom_range(NREG, CMD - 1) : $urandom_range(0, NREG - 1);
        spi_xfer(FL, 1'b1, a, d, 4, rdv);
      end else if (r <= 7) begin
        spi_xfer(FL, 1'b0, $urandom_range(0, CMD), d, 4, rdv);
      end else if (r == 8) begin
        spi_xfer(FL, 1'b1, CMD, d, 4, rdv);
      end else begin
        nb = $urandom_range(1, FL + 3);
        if (nb == FL) nb = FL + 2;
        spi_xfer(nb, 1'b1, $urandom_range(0, NREG - 1), d, 4, rdv);
      end
    end
    repeat (200) @(negedge CLK);

    do_reset();
    spi_xfer(FL - 1, 1'b1, 3, 16'h1234, 4, rdv);
    spi_xfer(FL, 1'b1, CMD, 16'h0003, 4, rdv);
    spi_xfer(FL, 1'b1, CMD, 16'h0001, 2, rdv);
    measure(200, fc, cn, bn, nl);
    chk("busy_cmd_err", BW'(ERR_CNT), BW'(2));
    chk("one_commit",   BW'(cn),      BW'(20));
    spi_xfer(FL, 1'b0, 3, 16'h0, 4, rdv);
    chk("short_no_wr",  BW'(rdv),     BW'(16'h0000));

    spi_xfer(FL, 1'b1, 3, 16'hA5C3, 4, rdv);
    spi_xfer(FL, 1'b1, CMD, 16'h0001, 4, rdv);
    ok = 0;
    for (int i = 0; i < 50 && ok == 0; i++) begin
      @(negedge CLK); #1;
      if (CFG_CONFIG) ok = 1;
    end
    chk("pulse_seen", BW'(ok), BW'(1));
    #1; NARST = 1'b0; model_reset();
    #1;
    chk("arst_config", BW'(CFG_CONFIG), BW'(0));
    chk("arst_busy",   BW'(BUSY),       BW'(0));
    chk("arst_bus",    CFG_BUS,         BW'(0));
    repeat (3) @(negedge CLK);
    #1; NARST = 1'b1;

    for (int i = 0; i < 300; i++) spi_xfer(2, 1'b1, 0, 16'h0, 2, rdv);
    repeat (5) @(negedge CLK);
    #1;
    chk("err_sat", BW'(ERR_CNT), BW'(255));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_cfg_regbank.md
Name: spi_cfg_regbank

Overview:
- Synthesizable SPI slave plus a parametrised register bank, replacing hand-sequenced initial-block SPI stimulus with a real configuration path.
- Serial frames write shadow registers. A commit command runs a sequencer that optionally pulses a soft reset, copies shadow to active, then pulses CFG_CONFIG.
- Sits between the off-chip SPI pins and the PLL control fields; active bank is flattened onto CFG_BUS.

Parameters:
- ADDR_W, 6, address field width in bits.
- DATA_W, 16, register width in bits.
- NREG, 32, number of registers; must satisfy NREG <= 2^ADDR_W - 1.
- RST_VAL, 0, reset value of every shadow and active register (DATA_W bits).
- RST_CYC, 20, CLK cycles CFG_NARST_OUT is held low on a soft-reset commit (>= 1).
- CFG_CYC, 20, CLK cycles CFG_CONFIG is held high per commit (>= 1).

Ports:
- CLK  in  1  system clock.
- NARST  in  1  asynchronous active-low reset.
- SCK  in  1  SPI clock (mode 0), async to CLK; frequency <= CLK/4.
- CSN  in  1  SPI chip select, active low.
- MOSI  in  1  SPI data in, MSB first.
- MISO  out  1  SPI data out.
- CFG_BUS  out  NREG*DATA_W  active registers; reg k occupies bits [k*DATA_W +: DATA_W].
- CFG_CONFIG  out  1  config-load pulse.
- CFG_NARST_OUT  out  1  soft reset to loop logic, active low.
- BUSY  out  1  commit sequencer not idle.
- ERR_CNT  out  8  saturating frame-error counter.

Behaviour:
- Reset: NARST low asynchronously clears all state.
  - Shadow and active registers = RST_VAL.
  - MISO=0, CFG_CONFIG=0, CFG_NARST_OUT=1, BUSY=0, ERR_CNT=0, FSM=IDLE, bit counter=0.
- Synchronisation: SCK, CSN, MOSI each pass through 2-flop synchronisers. SCK rise/fall and CSN rise/fall are edge-detected on the synchronised signals.
- Frame format, FL = 1+ADDR_W+DATA_W bits:
  - bit 0: W (1 = write, 0 = read).
  - next ADDR_W bits: address.
  - last DATA_W bits: data.
- Bit capture: CSN falling edge clears the bit counter. Each SCK rise while CSN is low shifts MOSI in and increments the counter; the counter saturates at FL+1.
- Frame end, on CSN rising edge:
  - Count != FL: frame discarded, ERR_CNT++.
  - Write, addr < NREG: shadow[addr] <= data.
  - Write, addr == 2^ADDR_W-1 (CMD): commit request. data[0] = apply, data[1] = soft reset.
  - Write to any other addr: ignored, no error.
  - Read frames: no state change.
- Readback: on the SCK rise completing the address field of a read frame, load shadow[addr] into the output shifter (0 if addr >= NREG).
  - MISO updates on each following SCK fall, MSB first.
  - MISO = 0 outside the data phase and while CSN is high.
- Commit FSM:
  - IDLE: a commit request with apply=1 moves to RSTP if soft reset=1, else to COPY. apply=0 does nothing.
  - RSTP: CFG_NARST_OUT=0 for exactly RST_CYC cycles, then COPY.
  - COPY: one cycle; active <= shadow for all registers; then PULSE.
  - PULSE: CFG_CONFIG=1 for exactly CFG_CYC cycles, then IDLE.
  - BUSY = (state != IDLE), registered.
  - Latency: CSN rise (synchronised) to first CFG_CONFIG=1 is 2 CLK without soft reset, RST_CYC+2 with it.
- Commit request while BUSY: ignored, ERR_CNT++.
- Shadow writes while BUSY: accepted. A write landing in the COPY cycle takes effect in that copy.
- ERR_CNT saturates at 255; it is never cleared except by NARST.
- NARST asserted mid-frame or mid-commit: everything returns to reset values; the partial frame is lost.
- CFG_BUS changes only in the COPY cycle.

Optional Feature:
- Macro SPI_PARITY_EN.
- Defined:
  - FL grows by 1; a final even-parity bit covers all preceding frame bits.
  - On a parity mismatch the frame is discarded (no write, no commit) and ERR_CNT++.
  - Readback data is followed by a parity bit on MISO.
- Undefined: no parity bit; behaviour exactly as above.

Test Plan:
- Reset, then read addr 5 -> MISO returns 0x0000; CFG_BUS all 0; CFG_NARST_OUT=1.
- Write addr 3 = 0xA5C3; read addr 3 -> MISO returns 0xA5C3; CFG_BUS[63:48] stays 0.
- Write addr 3 = 0xA5C3, then CMD=0x0001 -> BUSY high; CFG_CONFIG high for 20 cycles starting 2 CLK after CSN rise; CFG_BUS[63:48]=0xA5C3; CFG_NARST_OUT never low.
- CMD=0x0003 -> CFG_NARST_OUT low for 20 cycles, then COPY, then CFG_CONFIG high for 20 cycles; total BUSY = 41 cycles.
- 22-bit frame and a second CMD issued while BUSY -> ERR_CNT=2; shadow unchanged; one commit only.
- NARST pulsed low during PULSE -> CFG_CONFIG=0, BUSY=0, CFG_BUS=0 immediately; 300 short frames -> ERR_CNT=255.
